// File: rtl/result_relu_stage_pkg.sv
// result_relu_stage_pkg: shared FSM states, FP32 constants, SRAM addresses and the ReLU transform
package result_relu_stage_pkg;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, HEADER, DONE} state_t;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam int SIGN_BIT = 31;
  localparam int HEADER_ADDR = 0;
  localparam int FIRST_DATA_ADDR = 1;
  // Any word with the sign bit set (including -0 and negative NaN) clamps to +0.
  function automatic logic [31:0] relu_fp32(input logic [31:0] d, input logic en);
    return (en && d[SIGN_BIT]) ? FP32_POS_ZERO : d;
  endfunction
endpackage

// File: rtl/result_relu_stage_fp32_relu.sv
// fp32_relu: one registered stage applying optional ReLU to an FP32 word
// ports: clk, reset_n (sync active-low); relu_enable; in_valid/in_addr/in_data from the
// result SRAM; out_valid/out_addr/out_data/out_nonzero registered towards the output SRAM
module fp32_relu
  import result_relu_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              relu_enable,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_nonzero
);
  logic [DATA_W-1:0] xf;
  assign xf = relu_fp32(in_data, relu_enable);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_nonzero <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_addr    <= in_addr;
        out_data    <= xf;
        out_nonzero <= xf != '0;
      end
    end
  end
endmodule

// File: rtl/result_relu_stage.sv
// result_relu_stage: copies N FP32 results (optionally ReLU'd) to output SRAM and writes a header
// ports: clk, reset_n (sync active-low); dut_valid/dut_ready start-done handshake;
// num_elements, relu_enable latched at start; result SRAM read address/data (1-cycle latency);
// output SRAM write enable/address/data. Header at address 0 = {nonzero_count, N}.
module result_relu_stage
  import result_relu_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  logic [15:0]       num_elements,
  input  logic              relu_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_result_read_data,
  output logic              dut__tb__sram_output_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_output_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_output_write_data
);
  state_t state, state_nxt;
  logic [15:0] n_lat, nz_cnt, nz_nxt, rd_cnt;
  logic relu_lat, rd_vld, hdr_we, rl_vld, rl_nz;
  logic [ADDR_W-1:0] rd_idx, rl_addr;
  logic [DATA_W-1:0] rl_data, hdr_data;
  fp32_relu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_relu (
    .clk         (clk),
    .reset_n     (reset_n),
    .relu_enable (relu_lat),
    .in_valid    (rd_vld),
    .in_addr     (rd_idx),
    .in_data     (tb__dut__sram_result_read_data),
    .out_valid   (rl_vld),
    .out_addr    (rl_addr),
    .out_data    (rl_data),
    .out_nonzero (rl_nz)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  // The read counter is compared before it increments, so N=65535 never wraps.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (dut_valid) state_nxt = (num_elements == 16'd0) ? HEADER : READ;
      READ:    if (rd_cnt == n_lat) state_nxt = DRAIN;
      DRAIN:   state_nxt = HEADER;
      HEADER:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Element and header writes never overlap, so the write port is a mux of registers.
  always_comb begin
    dut_ready                          = state == IDLE;
    dut__tb__sram_result_read_address  = ADDR_W'(rd_cnt);
    dut__tb__sram_output_write_enable  = rl_vld | hdr_we;
    dut__tb__sram_output_write_address = hdr_we ? ADDR_W'(HEADER_ADDR) : rl_addr;
    dut__tb__sram_output_write_data    = hdr_we ? hdr_data : rl_data;
  end
  // The header is built in the cycle the last element is written, so it counts that element too.
  assign nz_nxt = nz_cnt + 16'(rl_vld & rl_nz);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_cnt   <= '0;
      rd_vld   <= 1'b0;
      rd_idx   <= '0;
      n_lat    <= '0;
      relu_lat <= 1'b0;
      nz_cnt   <= '0;
      hdr_we   <= 1'b0;
      hdr_data <= '0;
    end else begin
      rd_vld <= state == READ;
      rd_idx <= ADDR_W'(rd_cnt);
      nz_cnt <= nz_nxt;
      hdr_we <= state == HEADER;
      if (state == HEADER) hdr_data <= DATA_W'({nz_nxt, n_lat});
      if (state == IDLE && dut_valid) begin
        n_lat    <= num_elements;
        relu_lat <= relu_enable;
        nz_cnt   <= '0;
        rd_cnt   <= (num_elements == 16'd0) ? 16'd0 : 16'(FIRST_DATA_ADDR);
      end else if (state == READ && rd_cnt != n_lat) rd_cnt <= rd_cnt + 16'd1;
      else if (state == DONE) rd_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_result_relu_stage.sv
// tb_result_relu_stage: scoreboard bench for result_relu_stage with SRAM models
module tb_result_relu_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dut_valid = 1'b0;
  logic dut_ready;
  logic [15:0] num_elements = '0;
  logic relu_enable = 1'b0;
  logic [15:0] raddr;
  logic [31:0] rdata = '0;
  logic we;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic [31:0] rmem [0:255];
  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    int c;
  } wr_t;
  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_reads = 0;
  result_relu_stage dut (
    .clk                                (clk),
    .reset_n                            (reset_n),
    .dut_valid                          (dut_valid),
    .dut_ready                          (dut_ready),
    .num_elements                       (num_elements),
    .relu_enable                        (relu_enable),
    .dut__tb__sram_result_read_address  (raddr),
    .tb__dut__sram_result_read_data     (rdata),
    .dut__tb__sram_output_write_enable  (we),
    .dut__tb__sram_output_write_address (waddr),
    .dut__tb__sram_output_write_data    (wdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdata <= rmem[raddr[7:0]];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!dut_ready && raddr != 16'd0) busy_reads++;
    if (reset_n && we) begin
      if (exp_q.size() == 0) check("extra_write_pending", 0, 1);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", waddr, e.a);
        check("wr_data", wdata, e.d);
        check("wr_cycle", cyc - t0, e.c);
      end
    end
  end
  task automatic push_run(input int n, input logic relu, input int off);
    int nz;
    logic [31:0] o;
    nz = 0;
    for (int i = 1; i <= n; i++) begin
      o = (relu && rmem[i][31]) ? 32'h0 : rmem[i];
      if (o != 32'h0) nz++;
      exp_q.push_back('{16'(i), o, off + i + 2});
    end
    exp_q.push_back('{16'h0, {16'(nz), 16'(n)}, off + ((n == 0) ? 2 : n + 3)});
  endtask
  task automatic start(input int n, input logic relu, input logic hold);
    @(negedge clk);
    dut_valid = 1'b1;
    num_elements = 16'(n);
    relu_enable = relu;
    push_run(n, relu, 0);
    @(posedge clk);
    @(negedge clk);
    t0 = cyc - 1;
    if (!hold) dut_valid = 1'b0;
    check("busy_after_start", dut_ready, 0);
  endtask
  task automatic wait_ready(input int exp);
    for (int k = 0; k < 300 && !dut_ready; k++) @(negedge clk);
    check("ready_cycle", cyc - t0, exp);
  endtask
  task automatic run(input int n, input logic relu);
    start(n, relu, 1'b0);
    wait_ready((n == 0) ? 3 : n + 4);
    check("queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rmem[i] = 32'hDEAD_0000 | 32'(i);
    repeat (3) @(negedge clk);
    check("rst_ready", dut_ready, 1);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_raddr", raddr, 0);
    reset_n = 1'b1;
    rmem[1] = 32'h3F80_0000; rmem[2] = 32'hBF80_0000; rmem[3] = 32'h8000_0000; rmem[4] = 32'h4049_0FDB;
    run(4, 1'b1);
    run(4, 1'b0);
    busy_reads = 0;
    run(0, 1'b1);
    check("n0_no_reads", busy_reads, 0);
    rmem[1] = 32'h7FC0_0000; rmem[2] = 32'hFFC0_0000; rmem[3] = 32'h7F80_0000;
    run(3, 1'b1);
    for (int i = 1; i <= 10; i++) rmem[i] = (i % 2 == 0) ? 32'hC000_0000 + 32'(i) : 32'h4000_0000 + 32'(i);
    start(10, 1'b1, 1'b0);
    while (cyc - t0 < 3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_ready", dut_ready, 1);
    check("abort_we", we, 0);
    exp_q.delete();
    reset_n = 1'b1;
    run(2, 1'b1);
    rmem[1] = 32'h0000_0000; rmem[2] = 32'hC2F6_0000;
    start(2, 1'b0, 1'b1);
    push_run(2, 1'b0, 6);
    wait_ready(6);
    @(negedge clk);
    dut_valid = 1'b0;
    check("hold_restart_busy", dut_ready, 0);
    wait_ready(12);
    repeat (6) @(negedge clk);
    check("hold_single_restart", dut_ready, 1);
    check("hold_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
